cam_pixel_writer: RTL and testbench

- Upstream stage of the single-buffer controller: captures exactly one camera frame after reset and writes it into the single frame buffer.
- Input is an 8-bit, two-bytes-per-pixel RGB565 camera stream (vsync/href/data) that is already synchronous to clk.
- Output is 16-bit words on the frame-buffer write port, plus pixel_vsync, which drives the controller's pixel_vsync input.
- pixel_vsync reaches the active level when the frame is complete and holds there until reset.

---
 rtl/frame_pkg.sv | 25 ++
 rtl/cam_pixel_writer_if.sv | 32 +++
 rtl/byte_pair_packer.sv | 46 ++++
 rtl/cam_pixel_writer.sv | 140 ++++++++++++++
 tb/tb_cam_pixel_writer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the frame-capture path: FSM encodings, default
// geometry, and the frame-complete vsync level shared by writer and controller.
package frame_pkg;

  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_LINES  = 480;
  localparam int DEF_ADDR_W   = 19;

  // Level of pixel_vsync that means "frame written"; the buffer controller
  // imports the same constant so the two ends cannot disagree.
  localparam bit DEF_VSYNC_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    S_SYNC    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cam_pixel_writer_if.sv
// Camera byte stream in, frame-buffer write port out.
//
// Handshake: the camera side has no backpressure; a byte is consumed on every
// clk edge where cam_href=1. On the write side mem_wren is a valid-only strobe:
// mem_addr/mem_data are meaningful exactly in cycles where mem_wren=1, there is
// no ready, and the frame buffer must accept every strobed word.
interface cam_pixel_writer_if
  import frame_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              mem_wren;

  // master: the pixel writer (consumes camera bytes, drives the write port)
  modport master (
    input  cam_vsync, cam_href, cam_data,
    output mem_addr, mem_data, mem_wren
  );

  // slave: camera source plus frame-buffer write port
  modport slave (
    output cam_vsync, cam_href, cam_data,
    input  mem_addr, mem_data, mem_wren
  );

endinterface

// File: rtl/byte_pair_packer.sv
// Packs consecutive camera bytes into 16-bit {first, second} words and emits a
// one-cycle write strobe one cycle after the second byte is sampled.
module byte_pair_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,       // line end / frame start: drop any odd byte
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic        write_ok,    // owner allows this completed pair to be written
  output logic        pair_done,   // second byte of a pair sampled this cycle
  output logic [15:0] mem_data,
  output logic        mem_wren
);

  logic       phase_q;
  logic [7:0] hi_byte_q;

  assign pair_done = byte_valid & phase_q & ~clear;

  // Phase toggle, first-byte latch and registered word/strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= 1'b0;
      hi_byte_q <= 8'd0;
      mem_data  <= 16'd0;
      mem_wren  <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      if (clear) begin
        phase_q <= 1'b0;
      end else if (byte_valid) begin
        if (!phase_q) begin
          hi_byte_q <= byte_in;
          phase_q   <= 1'b1;
        end else begin
          phase_q <= 1'b0;
          if (write_ok) begin
            mem_data <= {hi_byte_q, byte_in};
            mem_wren <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/cam_pixel_writer.sv
// Captures exactly one RGB565 camera frame after reset into the frame buffer,
// then parks in S_DONE and signals completion on pixel_vsync.
module cam_pixel_writer
  import frame_pkg::*;
#(
  parameter int H_PIXELS     = DEF_H_PIXELS,
  parameter int V_LINES      = DEF_V_LINES,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter bit VSYNC_ACTIVE = DEF_VSYNC_ACTIVE,
  parameter bit CAM_VS_POL   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  cam_pixel_writer_if.master bus,
  output logic               pixel_vsync,
  output logic               frame_done,
  output logic               err_short,
  output logic               err_overflow,
  output state_t             state_dbg
);

  localparam int PW  = cnt_width(H_PIXELS);
  localparam int LW  = cnt_width(V_LINES);
  // One extra bit so the address counter can represent "frame full".
  localparam int WAW = ADDR_W + 1;

  localparam logic [PW-1:0]  PIX_MAX     = PW'(H_PIXELS);
  localparam logic [LW-1:0]  LINE_LAST   = LW'(V_LINES - 1);
  localparam logic [WAW-1:0] FRAME_WORDS = WAW'(H_PIXELS * V_LINES);

  state_t            state_q, state_d;
  logic              set_short;
  logic              href_q;
  logic [PW-1:0]     pixel_cnt;
  logic [LW-1:0]     line_cnt;
  logic [WAW-1:0]    word_addr;
  logic [ADDR_W-1:0] addr_q;

  logic              vs_active, in_capture, start_capture;
  logic              line_end, frame_complete;
  logic              byte_valid, write_ok, pair_done;
  logic [15:0]       pk_data;
  logic              pk_wren;

  assign vs_active      = (bus.cam_vsync == CAM_VS_POL);
  assign in_capture     = (state_q == S_CAPTURE);
  assign start_capture  = (state_q == S_ARM) && !vs_active;
  assign line_end       = in_capture && href_q && !bus.cam_href;
  assign frame_complete = line_end && (line_cnt == LINE_LAST);
  // Bytes arriving while the frame is being aborted by vsync are not packed.
  assign byte_valid     = in_capture && bus.cam_href && !vs_active;
  assign write_ok       = (pixel_cnt != PIX_MAX) && (word_addr != FRAME_WORDS);

  byte_pair_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_capture | line_end),
    .byte_valid (byte_valid),
    .byte_in    (bus.cam_data),
    .write_ok   (write_ok),
    .pair_done  (pair_done),
    .mem_data   (pk_data),
    .mem_wren   (pk_wren)
  );

  assign bus.mem_data = pk_data;
  assign bus.mem_wren = pk_wren;
  assign bus.mem_addr = addr_q;

  assign pixel_vsync  = (state_q == S_DONE) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
  assign frame_done   = (state_q == S_DONE);
  assign state_dbg    = state_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_SYNC;
    else        state_q <= state_d;
  end

  // Next-state: sync to a full frame, capture, then stay done until reset.
  always_comb begin
    state_d   = state_q;
    set_short = 1'b0;
    case (state_q)
      S_SYNC:    if (vs_active)  state_d = S_ARM;
      S_ARM:     if (!vs_active) state_d = S_CAPTURE;
      S_CAPTURE: begin
        // Completion is checked first so a last line ending together with
        // vsync is still a good frame.
        if (frame_complete) begin
          state_d = S_DONE;
        end else if (vs_active) begin
          state_d   = S_DONE;
          set_short = 1'b1;
        end
      end
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_SYNC;
    endcase
  end

  // Line/pixel/address counters, write address register and sticky errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      href_q       <= 1'b0;
      pixel_cnt    <= '0;
      line_cnt     <= '0;
      word_addr    <= '0;
      addr_q       <= '0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      // Masked outside capture so a line in progress at frame start is not
      // seen as a line end on the first capture cycle.
      href_q <= in_capture && bus.cam_href;
      if (set_short) err_short <= 1'b1;
      if (start_capture) begin
        pixel_cnt <= '0;
        line_cnt  <= '0;
        word_addr <= '0;
        addr_q    <= '0;
      end else if (in_capture) begin
        if (line_end) begin
          line_cnt  <= line_cnt + LW'(1);
          pixel_cnt <= '0;
        end
        if (pair_done) begin
          if (write_ok) begin
            addr_q    <= word_addr[ADDR_W-1:0];
            word_addr <= word_addr + WAW'(1);
            pixel_cnt <= pixel_cnt + PW'(1);
          end else begin
            err_overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_writer.sv
// Directed bench for cam_pixel_writer with a write scoreboard (4x2 frame).
module tb_cam_pixel_writer;
  import frame_pkg::*;

  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 3;

  logic   clk;
  logic   reset;
  logic   pixel_vsync, frame_done, err_short, err_overflow;
  state_t state_dbg;

  cam_pixel_writer_if #(.ADDR_W(AW)) bus ();

  cam_pixel_writer #(
    .H_PIXELS     (H),
    .V_LINES      (V),
    .ADDR_W       (AW),
    .VSYNC_ACTIVE (1'b0),
    .CAM_VS_POL   (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .pixel_vsync  (pixel_vsync),
    .frame_done   (frame_done),
    .err_short    (err_short),
    .err_overflow (err_overflow),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard: expected {addr, data} per write
  logic [AW+15:0] exp_q[$];
  int m_addr = 0;
  bit m_ovf = 0;
  bit model_on = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write the DUT makes must be the next expected one.
  always @(negedge clk) begin
    if (bus.mem_wren === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0)
        chk("write_addr_data", 32'({bus.mem_addr, bus.mem_data}), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr"},   32'(bus.mem_addr), 32'd0);
    chk({tag, "_data"},   32'(bus.mem_data), 32'd0);
    chk({tag, "_wren"},   32'(bus.mem_wren), 32'd0);
    chk({tag, "_pvsync"}, 32'(pixel_vsync),  32'd1);
    chk({tag, "_done"},   32'(frame_done),   32'd0);
    chk({tag, "_short"},  32'(err_short),    32'd0);
    chk({tag, "_ovf"},    32'(err_overflow), 32'd0);
    chk({tag, "_state"},  32'(state_dbg),    32'(S_SYNC));
  endtask

  task automatic check_done(input string tag, input bit exp_short, input bit exp_ovf);
    chk({tag, "_pvsync"}, 32'(pixel_vsync),   32'd0);
    chk({tag, "_done"},   32'(frame_done),    32'd1);
    chk({tag, "_short"},  32'(err_short),     32'(exp_short));
    chk({tag, "_ovf"},    32'(err_overflow),  32'(exp_ovf));
    chk({tag, "_state"},  32'(state_dbg),     32'(S_DONE));
    chk({tag, "_drain"},  32'(exp_q.size()),  32'd0);
  endtask

  // Assert reset asynchronously between clock edges and release it later.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    model_on = 0;
    #1;
    check_reset_vals(tag);
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    bus.cam_href  = 1'b0;
    bus.cam_vsync = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic vsync_pulse();
    bus.cam_vsync = 1'b1;
    tick();
    tick();
    bus.cam_vsync = 1'b0;
    m_addr   = 0;
    m_ovf    = 0;
    model_on = 1;
    tick();
    tick();
  endtask

  // Drive nbytes bytes base, base+1, ...; the model pairs them per line.
  task automatic send_bytes(input int nbytes, input int base, input bit close_line);
    logic [7:0] hi;
    logic [7:0] b;
    int pix;
    hi  = 8'd0;
    pix = 0;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'(base + i);
      if (i % 2 == 0) begin
        hi = b;
      end else if (model_on) begin
        if (pix < H && m_addr < H * V) begin
          exp_q.push_back({AW'(m_addr), hi, b});
          m_addr++;
          pix++;
        end else begin
          m_ovf = 1;
        end
      end
      bus.cam_href = 1'b1;
      bus.cam_data = b;
      tick();
    end
    if (close_line) begin
      bus.cam_href = 1'b0;
      tick();
      tick();
      tick();
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.cam_vsync = 1'b0;
    bus.cam_href  = 1'b0;
    bus.cam_data  = 8'd0;
    tick();
    tick();
    check_reset_vals("por");
    reset = 1'b1;
    tick();

    // Bytes before any vsync are ignored; nothing may be written.
    send_bytes(8, 8'h80, 1'b1);
    chk("pre_vsync_state", 32'(state_dbg), 32'(S_SYNC));
    chk("pre_vsync_pvsync", 32'(pixel_vsync), 32'd1);

    // Clean frame: 0x00..0x0F -> 8 writes at 0..7.
    vsync_pulse();
    chk("arm_to_capture", 32'(state_dbg), 32'(S_CAPTURE));
    send_bytes(8, 8'h00, 1'b1);
    chk("clean_mid_done", 32'(frame_done), 32'd0);
    send_bytes(8, 8'h08, 1'b1);
    model_on = 0;
    check_done("clean", 1'b0, m_ovf);

    // Camera activity in S_DONE is ignored.
    vsync_pulse();
    model_on = 0;
    send_bytes(8, 8'hA0, 1'b1);
    check_done("done_idle", 1'b0, 1'b0);

    // Reset while done: outputs drop back immediately.
    do_reset("rst_done");

    // Odd line: 7th byte dropped, next line re-pairs from its own byte 0.
    vsync_pulse();
    send_bytes(7, 8'h20, 1'b1);
    chk("odd_ovf", 32'(err_overflow), 32'd0);
    send_bytes(8, 8'h30, 1'b1);
    model_on = 0;
    check_done("odd", 1'b0, 1'b0);
    do_reset("rst_odd");

    // Overlong line: 5th pair suppressed, next line starts at address 4.
    vsync_pulse();
    send_bytes(10, 8'h40, 1'b1);
    chk("long_ovf_set", 32'(err_overflow), 32'(m_ovf));
    chk("long_model_addr", 32'(m_addr), 32'd4);
    send_bytes(8, 8'h50, 1'b1);
    model_on = 0;
    check_done("long", 1'b0, 1'b1);
    do_reset("rst_long");

    // Short frame: vsync returns after one line.
    vsync_pulse();
    send_bytes(8, 8'h60, 1'b1);
    bus.cam_vsync = 1'b1;
    tick();
    tick();
    model_on = 0;
    check_done("short", 1'b1, 1'b0);
    bus.cam_vsync = 1'b0;
    do_reset("rst_short");

    // Reset in the middle of a line during capture.
    vsync_pulse();
    send_bytes(3, 8'h70, 1'b0);
    chk("cap_state", 32'(state_dbg), 32'(S_CAPTURE));
    do_reset("rst_capture");

    // After a mid-capture reset the next full frame is captured from address 0.
    vsync_pulse();
    send_bytes(8, 8'hC0, 1'b1);
    send_bytes(8, 8'hD0, 1'b1);
    model_on = 0;
    check_done("recap", 1'b0, 1'b0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
